// File: rtl/can_btr_ctrl.sv
// CAN FD bit-timing shadow/active registers with host write validation and nominal/data phase FSM.
// Optional: define CAN_BTR_CFG_LOCK_EN to reject writes made outside reset_mode.
module can_btr_ctrl #(
    parameter logic [6:0] RST_BRP  = 7'd0,
    parameter logic [6:0] RST_PROP = 7'd1,
    parameter logic [5:0] RST_PS1  = 6'd3,
    parameter logic [5:0] RST_PS2  = 6'd2,
    parameter logic [4:0] RST_SJW  = 5'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reset_mode,
    input  logic        cfg_wr,
    input  logic        cfg_fd,
    input  logic [31:0] cfg_wdata,
    output logic        cfg_busy,
    output logic        cfg_ack,
    output logic        cfg_err,
    input  logic        en_fd_cfg,
    input  logic        sample_point,
    input  logic        sampled_bit,
    input  logic        rx_idle,
    input  logic        fdf_detected,
    input  logic        brs_field,
    input  logic        crc_delim_field,
    input  logic        go_error_frame,
    output logic [6:0]  prop_seg,
    output logic [5:0]  phase_seg_1,
    output logic [5:0]  phase_seg_2,
    output logic [6:0]  baud_r_presc,
    output logic [4:0]  sjw,
    output logic        triple_sampling,
    output logic [5:0]  prop_seg_fd,
    output logic [4:0]  phase_seg_1_fd,
    output logic [4:0]  phase_seg_2_fd,
    output logic [6:0]  baud_r_presc_fd,
    output logic [4:0]  sjw_fd,
    output logic        triple_sampling_fd,
    output logic        en_FD_rx,
    output logic        go_rx_brs_on,
    output logic        fdf_brs_r_on
);

    typedef enum logic {NOM, DATA} phase_e;

    localparam logic [31:0] RST_NOM_W = {1'b0, RST_SJW, RST_PS2, RST_PS1, RST_PROP, RST_BRP};
    localparam logic [28:0] RST_FD_W  = {1'b0, RST_SJW, RST_PS2[4:0], RST_PS1[4:0],
                                         RST_PROP[5:0], RST_BRP};

    phase_e      state_q, state_d;
    logic [31:0] act_nom_q, act_nom_d, shd_nom_q, shd_nom_d;
    logic [28:0] act_fd_q, act_fd_d, shd_fd_q, shd_fd_d;
    logic        pend_nom_q, pend_nom_d, pend_fd_q, pend_fd_d;
    logic        ack_q, ack_d, err_q, err_d;
    logic        en_fd_q, en_fd_d, brs_on_q, brs_on_d;

    logic        w_tsmp;
    logic [4:0]  w_sjw;
    logic [5:0]  w_ps2, w_ps1;
    logic [6:0]  w_prop, w_brp;
    logic [7:0]  seg_sum;
    logic        wr_bad, wr_ok, commit, busy;

    assign {w_tsmp, w_sjw, w_ps2, w_ps1, w_prop, w_brp} = cfg_wdata;
    assign seg_sum = {1'b0, w_prop} + {2'b00, w_ps1};
    assign busy    = pend_nom_q | pend_fd_q;

    always_comb begin
        wr_bad = (w_ps2 == 6'd0) || (seg_sum == 8'd0) || ({1'b0, w_sjw} > w_ps2)
              || (cfg_fd && (w_prop[6] || w_ps1[5] || w_ps2[5]));
`ifdef CAN_BTR_CFG_LOCK_EN
        wr_bad = wr_bad || !reset_mode;
`endif
        wr_ok = cfg_wr && !wr_bad;
    end

    // Commits are held off in DATA so the bit timing never switches mid-frame.
`ifdef CAN_BTR_CFG_LOCK_EN
    assign commit = (state_q == NOM) && reset_mode;
`else
    assign commit = (state_q == NOM) && (reset_mode || (rx_idle && sample_point));
`endif

    always_comb begin
        act_nom_d  = act_nom_q;
        act_fd_d   = act_fd_q;
        shd_nom_d  = shd_nom_q;
        shd_fd_d   = shd_fd_q;
        pend_nom_d = pend_nom_q;
        pend_fd_d  = pend_fd_q;
        en_fd_d    = en_fd_q;
        ack_d      = 1'b0;
        err_d      = cfg_wr && wr_bad;

        if (commit) begin
            en_fd_d = en_fd_cfg;
            ack_d   = busy;
            if (pend_nom_q) act_nom_d = shd_nom_q;
            if (pend_fd_q)  act_fd_d  = shd_fd_q;
            pend_nom_d = 1'b0;
            pend_fd_d  = 1'b0;
        end

        // A write in a commit cycle lands in the shadow and waits for the next commit.
        if (wr_ok) begin
            if (cfg_fd) begin
                shd_fd_d  = {w_tsmp, w_sjw, w_ps2[4:0], w_ps1[4:0], w_prop[5:0], w_brp};
                pend_fd_d = 1'b1;
            end else begin
                shd_nom_d  = cfg_wdata;
                pend_nom_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        brs_on_d = 1'b0;
        unique case (state_q)
            NOM: begin
                if (!reset_mode && !go_error_frame && en_fd_q && fdf_detected
                    && brs_field && sample_point && sampled_bit) begin
                    state_d  = DATA;
                    brs_on_d = 1'b1;
                end
            end
            DATA: begin
                if (reset_mode || go_error_frame || rx_idle || !en_fd_q
                    || (crc_delim_field && sample_point))
                    state_d = NOM;
            end
            default: state_d = NOM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NOM;
            act_nom_q  <= RST_NOM_W;
            act_fd_q   <= RST_FD_W;
            shd_nom_q  <= RST_NOM_W;
            shd_fd_q   <= RST_FD_W;
            pend_nom_q <= 1'b0;
            pend_fd_q  <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            en_fd_q    <= 1'b0;
            brs_on_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_nom_q  <= act_nom_d;
            act_fd_q   <= act_fd_d;
            shd_nom_q  <= shd_nom_d;
            shd_fd_q   <= shd_fd_d;
            pend_nom_q <= pend_nom_d;
            pend_fd_q  <= pend_fd_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            en_fd_q    <= en_fd_d;
            brs_on_q   <= brs_on_d;
        end
    end

    assign cfg_busy     = busy;
    assign cfg_ack      = ack_q;
    assign cfg_err      = err_q;
    assign en_FD_rx     = en_fd_q;
    assign go_rx_brs_on = brs_on_q;
    assign fdf_brs_r_on = (state_q == DATA);

    assign {triple_sampling, sjw, phase_seg_2, phase_seg_1, prop_seg, baud_r_presc} = act_nom_q;
    assign {triple_sampling_fd, sjw_fd, phase_seg_2_fd, phase_seg_1_fd,
            prop_seg_fd, baud_r_presc_fd} = act_fd_q;

endmodule

// File: tb/tb_can_btr_ctrl.sv
// Directed bench for can_btr_ctrl: config validation, commit timing, phase FSM.
module tb_can_btr_ctrl;

    logic        clk = 1'b0;
    logic        rst, reset_mode, cfg_wr, cfg_fd;
    logic [31:0] cfg_wdata;
    logic        cfg_busy, cfg_ack, cfg_err;
    logic        en_fd_cfg, sample_point, sampled_bit, rx_idle;
    logic        fdf_detected, brs_field, crc_delim_field, go_error_frame;
    logic [6:0]  prop_seg, baud_r_presc, baud_r_presc_fd;
    logic [5:0]  phase_seg_1, phase_seg_2, prop_seg_fd;
    logic [4:0]  sjw, sjw_fd, phase_seg_1_fd, phase_seg_2_fd;
    logic        triple_sampling, triple_sampling_fd;
    logic        en_FD_rx, go_rx_brs_on, fdf_brs_r_on;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    can_btr_ctrl dut (
        .clk(clk), .rst(rst), .reset_mode(reset_mode), .cfg_wr(cfg_wr), .cfg_fd(cfg_fd),
        .cfg_wdata(cfg_wdata), .cfg_busy(cfg_busy), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .en_fd_cfg(en_fd_cfg), .sample_point(sample_point), .sampled_bit(sampled_bit),
        .rx_idle(rx_idle), .fdf_detected(fdf_detected), .brs_field(brs_field),
        .crc_delim_field(crc_delim_field), .go_error_frame(go_error_frame),
        .prop_seg(prop_seg), .phase_seg_1(phase_seg_1), .phase_seg_2(phase_seg_2),
        .baud_r_presc(baud_r_presc), .sjw(sjw), .triple_sampling(triple_sampling),
        .prop_seg_fd(prop_seg_fd), .phase_seg_1_fd(phase_seg_1_fd),
        .phase_seg_2_fd(phase_seg_2_fd), .baud_r_presc_fd(baud_r_presc_fd),
        .sjw_fd(sjw_fd), .triple_sampling_fd(triple_sampling_fd),
        .en_FD_rx(en_FD_rx), .go_rx_brs_on(go_rx_brs_on), .fdf_brs_r_on(fdf_brs_r_on)
    );

    function automatic logic [31:0] pack(input logic t, input logic [4:0] sj,
                                         input logic [5:0] p2, input logic [5:0] p1,
                                         input logic [6:0] pr, input logic [6:0] br);
        return {t, sj, p2, p1, pr, br};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enter_data();
        fdf_detected = 1; brs_field = 1; sample_point = 1; sampled_bit = 1;
        step();
        fdf_detected = 0; brs_field = 0; sample_point = 0; sampled_bit = 0;
    endtask

    initial begin
        rst = 1; reset_mode = 0; cfg_wr = 0; cfg_fd = 0; cfg_wdata = '0;
        en_fd_cfg = 0; sample_point = 0; sampled_bit = 0; rx_idle = 0;
        fdf_detected = 0; brs_field = 0; crc_delim_field = 0; go_error_frame = 0;
        step(); step();
        rst = 0;

        chk("rst_brp", baud_r_presc, 0);
        chk("rst_prop", prop_seg, 1);
        chk("rst_ps1", phase_seg_1, 3);
        chk("rst_ps2", phase_seg_2, 2);
        chk("rst_sjw", sjw, 1);
        chk("rst_prop_fd", prop_seg_fd, 1);
        chk("rst_ps2_fd", phase_seg_2_fd, 2);
        chk("rst_sjw_fd", sjw_fd, 1);
        chk("rst_en_fd", en_FD_rx, 0);
        chk("rst_phase", fdf_brs_r_on, 0);
        chk("rst_busy", cfg_busy, 0);

        // nominal write in reset mode
        reset_mode = 1; en_fd_cfg = 1;
        cfg_wr = 1; cfg_fd = 0; cfg_wdata = pack(1'b0, 5'd2, 6'd3, 6'd6, 7'd5, 7'd4);
        step();
        cfg_wr = 0;
        chk("t1_busy", cfg_busy, 1);
        chk("t1_ack_early", cfg_ack, 0);
        chk("t1_brp_early", baud_r_presc, 0);
        chk("t1_en_fd", en_FD_rx, 1);
        step();
        chk("t1_ack", cfg_ack, 1);
        chk("t1_busy_clr", cfg_busy, 0);
        chk("t1_brp", baud_r_presc, 4);
        chk("t1_prop", prop_seg, 5);
        chk("t1_ps1", phase_seg_1, 6);
        chk("t1_ps2", phase_seg_2, 3);
        chk("t1_sjw", sjw, 2);
        step();
        chk("t1_ack_pulse", cfg_ack, 0);

        // rejected writes
        cfg_wr = 1; cfg_wdata = pack(1'b0, 5'd4, 6'd3, 6'd6, 7'd5, 7'd9);
        step();
        cfg_wr = 0;
        chk("t2_err", cfg_err, 1);
        chk("t2_busy", cfg_busy, 0);
        step();
        chk("t2_err_pulse", cfg_err, 0);
        chk("t2_brp", baud_r_presc, 4);
        chk("t2_ps2", phase_seg_2, 3);
        cfg_wr = 1; cfg_wdata = pack(1'b0, 5'd0, 6'd0, 6'd6, 7'd5, 7'd9);
        step();
        chk("t2_ps2_zero", cfg_err, 1);
        cfg_wdata = pack(1'b0, 5'd0, 6'd2, 6'd0, 7'd0, 7'd9);
        step();
        chk("t2_seg_zero", cfg_err, 1);
        cfg_fd = 1; cfg_wdata = pack(1'b0, 5'd1, 6'd2, 6'd2, 7'd64, 7'd9);
        step();
        cfg_wr = 0; cfg_fd = 0;
        chk("t2_fd_wide", cfg_err, 1);
        chk("t2_fd_busy", cfg_busy, 0);
        step();
        chk("t2_ps2_fd", phase_seg_2_fd, 2);
        chk("t2_brp_keep", baud_r_presc, 4);

        // phase FSM: recessive BRS enters DATA
        reset_mode = 0;
        enter_data();
        chk("t4_brs_pulse", go_rx_brs_on, 1);
        chk("t4_data", fdf_brs_r_on, 1);
        step();
        chk("t4_brs_once", go_rx_brs_on, 0);
        chk("t4_data_hold", fdf_brs_r_on, 1);

        // data-set write while in DATA waits for an idle NOM sample point
        cfg_wr = 1; cfg_fd = 1; cfg_wdata = pack(1'b1, 5'd1, 6'd4, 6'd4, 7'd3, 7'd2);
        step();
        cfg_wr = 0; cfg_fd = 0;
        chk("t3_busy", cfg_busy, 1);
        chk("t3_ps2_hold", phase_seg_2_fd, 2);
        rx_idle = 1; sample_point = 1;
        step();
        chk("t3_to_nom", fdf_brs_r_on, 0);
        chk("t3_busy_data", cfg_busy, 1);
        chk("t3_ps2_data", phase_seg_2_fd, 2);
        sample_point = 0;
        step();
        chk("t3_busy_nosp", cfg_busy, 1);
        sample_point = 1;
        step();
        rx_idle = 0; sample_point = 0;
        chk("t3_ack", cfg_ack, 1);
        chk("t3_busy_clr", cfg_busy, 0);
        chk("t3_ps2_fd", phase_seg_2_fd, 4);
        chk("t3_ps1_fd", phase_seg_1_fd, 4);
        chk("t3_prop_fd", prop_seg_fd, 3);
        chk("t3_brp_fd", baud_r_presc_fd, 2);
        chk("t3_tsmp_fd", triple_sampling_fd, 1);
        chk("t3_nom_keep", baud_r_presc, 4);

        // CRC delimiter sample point leaves DATA
        enter_data();
        chk("t4_data2", fdf_brs_r_on, 1);
        crc_delim_field = 1;
        step();
        chk("t4_crc_hold", fdf_brs_r_on, 1);
        sample_point = 1;
        step();
        crc_delim_field = 0; sample_point = 0;
        chk("t4_crc_exit", fdf_brs_r_on, 0);

        // error frame coincident with CRC delimiter
        enter_data();
        go_error_frame = 1; crc_delim_field = 1; sample_point = 1;
        step();
        go_error_frame = 0; crc_delim_field = 0; sample_point = 0;
        chk("t5_err_exit", fdf_brs_r_on, 0);
        chk("t5_no_brs", go_rx_brs_on, 0);

        // dominant BRS stays nominal
        fdf_detected = 1; brs_field = 1; sample_point = 1; sampled_bit = 0;
        step();
        fdf_detected = 0; brs_field = 0; sample_point = 0;
        chk("t5_dom_phase", fdf_brs_r_on, 0);
        chk("t5_dom_pulse", go_rx_brs_on, 0);

        // operational-mode write
        cfg_wr = 1; cfg_wdata = pack(1'b0, 5'd1, 6'd5, 6'd7, 7'd8, 7'd11);
        step();
        cfg_wr = 0;
`ifdef CAN_BTR_CFG_LOCK_EN
        chk("t6_lock_err", cfg_err, 1);
        chk("t6_lock_busy", cfg_busy, 0);
`else
        chk("t6_err", cfg_err, 0);
        chk("t6_busy", cfg_busy, 1);
        rx_idle = 1; sample_point = 1;
        step();
        rx_idle = 0; sample_point = 0;
        chk("t6_ack", cfg_ack, 1);
        chk("t6_brp", baud_r_presc, 11);
        chk("t6_ps2", phase_seg_2, 5);
`endif

        // disabling FD at a commit point blocks DATA entry
        reset_mode = 1; en_fd_cfg = 0;
        step();
        reset_mode = 0;
        chk("t7_en_fd_off", en_FD_rx, 0);
        enter_data();
        chk("t7_no_data", fdf_brs_r_on, 0);
        chk("t7_no_pulse", go_rx_brs_on, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
